// File: rtl/nv_ram_rwsp_fifo_ctrl_pkg.sv
// rtl/nv_ram_rwsp_fifo_ctrl_pkg.sv - shared constants for the two-port RAM FIFO sequencer
//
// Purpose: default geometry of the FIFO (DEPTH x DW, address and counter widths)
//          and a helper that derives the minimum occupancy counter width.
// Ports:   none (package).

package nv_ram_rwsp_fifo_ctrl_pkg;

    localparam int DEF_DEPTH = 245;
    localparam int DEF_AW    = 8;
    localparam int DEF_DW    = 257;
    localparam int DEF_CW    = 9;

    // Smallest counter width able to hold 0..depth inclusive.
    function automatic int cw_for_depth(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/nv_ram_rwsp_fifo_ctrl_if.sv
// rtl/nv_ram_rwsp_fifo_ctrl_if.sv - push/pop handshake and RAM port bundle
//
// Purpose: groups the push side (wr_*), pop side (rd_*) and the RAM write/read
//          port signals of the FIFO sequencer.
// Ports:   slave  - the sequencer: takes wr_pvld/wr_pd/rd_prdy/ram_dout, drives the rest.
//          master - the environment (producer, consumer and RAM instance).

interface nv_ram_rwsp_fifo_ctrl_if
    import nv_ram_rwsp_fifo_ctrl_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);

    logic          wr_pvld;
    logic          wr_prdy;
    logic [DW-1:0] wr_pd;
    logic          rd_pvld;
    logic          rd_prdy;
    logic [DW-1:0] rd_pd;
    logic          ram_we;
    logic [AW-1:0] ram_wa;
    logic [DW-1:0] ram_di;
    logic          ram_re;
    logic [AW-1:0] ram_ra;
    logic          ram_ore;
    logic [DW-1:0] ram_dout;

    modport slave (
        input  wr_pvld, wr_pd, rd_prdy, ram_dout,
        output wr_prdy, rd_pvld, rd_pd, ram_we, ram_wa, ram_di, ram_re, ram_ra, ram_ore
    );

    modport master (
        output wr_pvld, wr_pd, rd_prdy, ram_dout,
        input  wr_prdy, rd_pvld, rd_pd, ram_we, ram_wa, ram_di, ram_re, ram_ra, ram_ore
    );

endinterface

// File: rtl/nv_ram_rwsp_fifo_ctrl_rdpipe.sv
// rtl/nv_ram_rwsp_fifo_ctrl_rdpipe.sv - two-stage RAM read pipeline valid tracking
//
// Purpose: tracks which RAM read stages hold data (s1 = address latched, s2 =
//          output register loaded) and generates re/ore so a stall at the pop
//          port propagates back without a skid buffer.
// Ports:   clk, rst_n (async active-low)
//          i_avail    - an unissued entry exists in the RAM
//          i_rd_prdy  - consumer ready
//          o_re/o_ore - RAM address-latch / output-register enables
//          o_s1_vld/o_s2_vld - stage occupancy (o_s2_vld is the pop valid)

module nv_ram_rwsp_fifo_rdpipe (
    input  logic clk,
    input  logic rst_n,
    input  logic i_avail,
    input  logic i_rd_prdy,
    output logic o_re,
    output logic o_ore,
    output logic o_s1_vld,
    output logic o_s2_vld
);

    logic r_s1_vld;
    logic r_s2_vld;
    logic w_s1_adv;
    logic w_s2_adv;

    // A stage may accept new data when it is empty or its content moves on.
    assign w_s2_adv = !r_s2_vld | i_rd_prdy;
    assign w_s1_adv = !r_s1_vld | w_s2_adv;

    // With re/ore low the RAM's ra_d and dout_r hold, keeping rd_pd stable.
    assign o_re  = i_avail & w_s1_adv;
    assign o_ore = r_s1_vld & w_s2_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_s2_vld <= 1'b0;
        end else begin
            r_s1_vld <= o_re  | (r_s1_vld & !w_s2_adv);
            r_s2_vld <= o_ore | (r_s2_vld & !i_rd_prdy);
        end
    end

    assign o_s1_vld = r_s1_vld;
    assign o_s2_vld = r_s2_vld;

endmodule

// File: rtl/nv_ram_rwsp_fifo_ctrl.sv
// rtl/nv_ram_rwsp_fifo_ctrl.sv - valid/ready FIFO sequencer for a 2-cycle-read two-port RAM
//
// Purpose: owns write/read pointers and occupancy of a FIFO built on an external
//          single-clock two-port RAM; RAM dout is the pop payload directly.
// Ports:   nvdla_core_clk, nvdla_core_rstn (async active-low)
//          bus          - push/pop handshake and RAM port (slave modport)
//          fifo_count   - entries written but not yet issued to read
//          ctrl_idle    - nothing stored and no read in flight
//          wr_stall_cnt - saturating count of cycles with wr_pvld & !wr_prdy
//                         (present only when NV_FIFO_CTRL_PERF_EN is defined)

module nv_ram_rwsp_fifo_ctrl
    import nv_ram_rwsp_fifo_ctrl_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW,
    parameter int CW    = DEF_CW
) (
    input  logic                   nvdla_core_clk,
    input  logic                   nvdla_core_rstn,
    nv_ram_rwsp_fifo_ctrl_if.slave bus,
`ifdef NV_FIFO_CTRL_PERF_EN
    output logic [31:0]            wr_stall_cnt,
`endif
    output logic [CW-1:0]          fifo_count,
    output logic                   ctrl_idle
);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_wr_prdy;
    logic [CW-1:0] w_count_nxt;
    logic          w_push;
    logic          w_re;
    logic          w_ore;
    logic          w_s1_vld;
    logic          w_s2_vld;
    logic [DW-1:0] w_wr_pd;
    logic [DW-1:0] w_rd_pd;

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign w_push      = bus.wr_pvld & r_wr_prdy;
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_re);

    nv_ram_rwsp_fifo_rdpipe u_rdpipe (
        .clk       (nvdla_core_clk),
        .rst_n     (nvdla_core_rstn),
        .i_avail   (r_count != '0),
        .i_rd_prdy (bus.rd_prdy),
        .o_re      (w_re),
        .o_ore     (w_ore),
        .o_s1_vld  (w_s1_vld),
        .o_s2_vld  (w_s2_vld)
    );

    // A pushed entry reaches count at the same edge it lands in the RAM, so its
    // read is issued no earlier than the following cycle.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_wr_prdy <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_re) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count   <= w_count_nxt;
            r_wr_prdy <= (w_count_nxt < CW'(DEPTH));
        end
    end

    assign w_wr_pd     = bus.wr_pd;
    assign w_rd_pd     = bus.ram_dout;

    assign bus.wr_prdy = r_wr_prdy;
    assign bus.ram_we  = w_push;
    assign bus.ram_wa  = r_wr_ptr;
    assign bus.ram_di  = w_wr_pd;
    assign bus.ram_re  = w_re;
    assign bus.ram_ra  = r_rd_ptr;
    assign bus.ram_ore = w_ore;
    assign bus.rd_pvld = w_s2_vld;
    assign bus.rd_pd   = w_rd_pd;

    assign fifo_count  = r_count;
    assign ctrl_idle   = (r_count == '0) & !w_s1_vld & !w_s2_vld;

`ifdef NV_FIFO_CTRL_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_stall_cnt <= '0;
        end else if (bus.wr_pvld && !r_wr_prdy && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign wr_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_nv_ram_rwsp_fifo_ctrl.sv
// tb/tb_nv_ram_rwsp_fifo_ctrl.sv - self-checking bench for nv_ram_rwsp_fifo_ctrl

module tb_nv_ram_rwsp_fifo_ctrl;
    import nv_ram_rwsp_fifo_ctrl_pkg::*;

    localparam int DEPTH = DEF_DEPTH;
    localparam int AW    = DEF_AW;
    localparam int DW    = DEF_DW;
    localparam int CW    = DEF_CW;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    nv_ram_rwsp_fifo_ctrl_if #(.AW(AW), .DW(DW)) bus ();
    logic [CW-1:0] fifo_count;
    logic          ctrl_idle;
`ifdef NV_FIFO_CTRL_PERF_EN
    logic [31:0]   wr_stall_cnt;
`endif

    nv_ram_rwsp_fifo_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .CW(CW)) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .bus             (bus),
`ifdef NV_FIFO_CTRL_PERF_EN
        .wr_stall_cnt    (wr_stall_cnt),
`endif
        .fifo_count      (fifo_count),
        .ctrl_idle       (ctrl_idle)
    );

    // RAM beside the sequencer: re latches the address, ore latches the data.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] ra_d;
    logic [DW-1:0] dout_r;
    always @(posedge clk) begin
        if (bus.ram_we)  mem[bus.ram_wa] <= bus.ram_di;
        if (bus.ram_re)  ra_d <= bus.ram_ra;
        if (bus.ram_ore) dout_r <= mem[ra_d];
    end
    assign bus.ram_dout = dout_r;

    logic [DW-1:0] exp_q [$];
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [AW-1:0] m_wa, m_ra;
    logic          p_stall, p_cnt_nz;
    logic [DW-1:0] p_pd;
    int            cyc_n = 0;
    int            first_pop, last_pop, n_pops, n_acc;

    typedef struct {
        logic          pvld;
        logic [7:0]    pd;
        logic          prdy;
        logic          e_prdy;
        logic          e_pvld;
        logic [CW-1:0] e_cnt;
        logic          e_idle;
    } vec_t;
    vec_t tv [8];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    task automatic clear_model();
        exp_q.delete();
        m_wa = '0; m_ra = '0;
        p_stall = 1'b0; p_cnt_nz = 1'b0; p_pd = '0;
        first_pop = -1; last_pop = -1; n_pops = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_wr_prdy"}, bus.wr_prdy, 0);
        chk({tag, "_rd_pvld"}, bus.rd_pvld, 0);
        chk({tag, "_ram_we"}, bus.ram_we, 0);
        chk({tag, "_ram_re"}, bus.ram_re, 0);
        chk({tag, "_ram_ore"}, bus.ram_ore, 0);
        chk({tag, "_fifo_count"}, fifo_count, 0);
        chk({tag, "_ctrl_idle"}, ctrl_idle, 1);
`ifdef NV_FIFO_CTRL_PERF_EN
        chk({tag, "_stall_cnt"}, wr_stall_cnt, 0);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.wr_pvld = 1'b0; bus.rd_prdy = 1'b0; bus.wr_pd = '0;
        rstn = 1'b0;
        #1;
        check_reset_vals("rst");
        @(negedge clk);
        #1;
        rstn = 1'b1;
        clear_model();
    endtask

    // One clock: drive at negedge, sample 1 time unit later, score push/pop.
    task automatic cyc(input logic pvld, input logic gate, input logic [DW-1:0] pd, input logic prdy);
        @(negedge clk);
        bus.wr_pvld = pvld & (!gate | bus.wr_prdy);
        bus.wr_pd   = pd;
        bus.rd_prdy = prdy;
        #1;
        cyc_n++;
        chk("ram_we", bus.ram_we, bus.wr_pvld & bus.wr_prdy);
        if (p_stall) begin
            chk("stall_hold_vld", bus.rd_pvld, 1);
            chk("stall_hold_pd", bus.rd_pd, p_pd);
            if (p_cnt_nz && bus.rd_pvld && !bus.rd_prdy) begin
                chk("stall_re", bus.ram_re, 0);
                chk("stall_ore", bus.ram_ore, 0);
            end
        end
        if (bus.rd_pvld && bus.rd_prdy) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL pop_unexpected: got %0h want none", bus.rd_pd);
            end else begin
                chk("rd_pd", bus.rd_pd, exp_q.pop_front());
            end
            n_pops++;
            if (first_pop < 0) first_pop = cyc_n;
            last_pop = cyc_n;
        end
        if (bus.ram_we) begin
            chk("ram_wa", bus.ram_wa, m_wa);
            exp_q.push_back(pd);
            m_wa = wrap_inc(m_wa);
        end
        if (bus.ram_re) begin
            chk("ram_ra", bus.ram_ra, m_ra);
            m_ra = wrap_inc(m_ra);
        end
        p_stall  = bus.rd_pvld & !bus.rd_prdy;
        p_pd     = bus.rd_pd;
        p_cnt_nz = (fifo_count != '0);
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 700 && (exp_q.size() != 0 || !ctrl_idle); k++) begin
            cyc(1'b0, 1'b0, '0, 1'b1);
        end
        chk({tag, "_drained"}, DW'(exp_q.size()), 0);
        chk({tag, "_idle"}, ctrl_idle, 1);
        chk({tag, "_count0"}, fifo_count, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        int n;
        logic [3:0] pat;
        bus.wr_pvld = 1'b0; bus.rd_prdy = 1'b0; bus.wr_pd = '0;
        clear_model();

        // Four pushes with rd_prdy=1: per-cycle handshake, count and idle.
        tv[0] = '{1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 9'd0, 1'b1};
        tv[1] = '{1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 9'd1, 1'b0};
        tv[2] = '{1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 9'd1, 1'b0};
        tv[3] = '{1'b1, 8'h04, 1'b1, 1'b1, 1'b1, 9'd1, 1'b0};
        tv[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 9'd1, 1'b0};
        tv[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 9'd0, 1'b0};
        tv[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 9'd0, 1'b0};
        tv[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 9'd0, 1'b1};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cyc(tv[i].pvld, 1'b0, DW'(tv[i].pd), tv[i].prdy);
            chk($sformatf("t1_wr_prdy[%0d]", i), bus.wr_prdy, tv[i].e_prdy);
            chk($sformatf("t1_rd_pvld[%0d]", i), bus.rd_pvld, tv[i].e_pvld);
            chk($sformatf("t1_count[%0d]", i), fifo_count, tv[i].e_cnt);
            chk($sformatf("t1_idle[%0d]", i), ctrl_idle, tv[i].e_idle);
        end
        chk("t1_pops", DW'(n_pops), 4);
        chk("t1_empty", DW'(exp_q.size()), 0);

        // Fill with consumer stalled. Two entries move into s1/s2, so the
        // unissued count reaches DEPTH after DEPTH+2 accepted pushes.
        do_reset();
        n_acc = 0;
        for (int k = 0; k < 400; k++) begin
            cyc(1'b1, 1'b1, DW'(n_acc % DEPTH), 1'b0);
            if (bus.ram_we) n_acc++;
            if (k > 0 && !bus.wr_prdy) break;
        end
        chk("fill_accepted", DW'(n_acc), DW'(DEPTH + 2));
        chk("fill_count", fifo_count, DEPTH);
        chk("fill_prdy", bus.wr_prdy, 0);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 1'b0, '1, 1'b0);
            chk("full_no_we", bus.ram_we, 0);
        end
        cyc(1'b0, 1'b0, '0, 1'b1);
        chk("drain_first_re", bus.ram_re, 1);
        chk("drain_prdy_low", bus.wr_prdy, 0);
`ifdef NV_FIFO_CTRL_PERF_EN
        chk("perf_stall_cnt", wr_stall_cnt, 5);
`endif
        cyc(1'b0, 1'b0, '0, 1'b1);
        chk("drain_prdy_rerise", bus.wr_prdy, 1);
        drain("fill");
        chk("fill_pops", DW'(n_pops), DW'(DEPTH + 2));

        // 600 incrementing words streamed: pointer wrap and one pop per cycle.
        do_reset();
        n = 0;
        for (int k = 0; k < 800 && n < 600; k++) begin
            cyc(1'b1, 1'b1, {DW'(n) << 128} | DW'(n), 1'b1);
            if (bus.ram_we) n++;
        end
        chk("wrap_pushes", DW'(n), 600);
        drain("wrap");
        chk("wrap_pops", DW'(n_pops), 600);
        chk("wrap_rate", DW'(last_pop - first_pop), 599);

        // Consumer ready pattern 1,0,0,1 while streaming random payloads.
        do_reset();
        pat = 4'b1001;
        n = 0;
        for (int k = 0; k < 80; k++) begin
            cyc(1'b1, 1'b1, {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), 1'b1}, pat[k % 4]);
            if (bus.ram_we) n++;
        end
        drain("bp");
        chk("bp_pops", DW'(n_pops), DW'(n));

        // Async reset with entries stored and both read stages full.
        do_reset();
        for (int k = 0; k < 10; k++) cyc(1'b1, 1'b1, DW'(k + 100), 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0);
        chk("ar_pre_count", fifo_count, 8);
        chk("ar_pre_pvld", bus.rd_pvld, 1);
        #2;
        rstn = 1'b0;
        #1;
        check_reset_vals("ar");
        clear_model();
        @(negedge clk);
        #1;
        rstn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, 1'b0, '0, 1'b1);
            chk("ar_no_pop", bus.rd_pvld, 0);
        end
        cyc(1'b1, 1'b1, DW'(77), 1'b1);
        drain("ar");
        chk("ar_new_pop", DW'(n_pops), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
